// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch T0-T2, per-class execute,
// Moore strobes decoded from the state register and IR.
module control_sequencer (
    input  logic        Clock,
    input  logic        clear_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        Write,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [4:0]  alu_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        RESET = 4'd0,
        T0, T1, T2, T3, T4, T5, T6, T7,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_NOP, C_HALT
    } iclass_t;

    state_t     state;
    state_t     next_state;
    state_t     last_state;
    state_t     boundary;
    iclass_t    iclass;
    logic [4:0] opcode;
    logic [4:0] alu_code;
    logic [15:0] ra_sel;
    logic [15:0] rb_sel;
    logic [15:0] rc_sel;
    logic [15:0] base_sel;
    logic        unused_ir;

    assign opcode   = IR[31:27];
    assign ra_sel   = 16'd1 << IR[26:23];
    assign rb_sel   = 16'd1 << IR[22:19];
    assign rc_sel   = 16'd1 << IR[18:15];
    // Memory-address base: R0 reads as zero, so no register drives the bus.
    assign base_sel = (IR[22:19] == 4'd0) ? '0 : rb_sel;
    // Immediate bits go straight to the datapath sign-extender, not decoded here.
    assign unused_ir = ^IR[14:0];

    always_comb begin
        case (opcode)
            5'd0:                              iclass = C_LD;
            5'd1:                              iclass = C_LDI;
            5'd2:                              iclass = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd9, 5'd10, 5'd11:          iclass = C_ALU;
            5'd12, 5'd13, 5'd14:               iclass = C_IMM;
            5'd15, 5'd16:                      iclass = C_MULDIV;
            5'd17, 5'd18:                      iclass = C_NEGNOT;
            5'd27:                             iclass = C_HALT;
            default:                           iclass = C_NOP;
        endcase
    end

    always_comb begin
        case (iclass)
            C_ALU, C_MULDIV, C_NEGNOT: alu_code = opcode;
            C_IMM: begin
                case (opcode)
                    5'd12:   alu_code = 5'd3;
                    5'd13:   alu_code = 5'd5;
                    default: alu_code = 5'd6;
                endcase
            end
            C_LD, C_LDI, C_ST: alu_code = 5'd3;
            default:           alu_code = 5'd0;
        endcase
    end

    always_comb begin
        case (iclass)
            C_NEGNOT:             last_state = T4;
            C_ALU, C_IMM, C_LDI:  last_state = T5;
            C_MULDIV:             last_state = T6;
            C_LD, C_ST:           last_state = T7;
            default:              last_state = T2;
        endcase
    end

    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) state <= RESET;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        boundary   = Stop ? HALT : T0;
        case (state)
            RESET: next_state = T0;
            T0:    next_state = T1;
            T1:    next_state = T2;
            T2: begin
                if (iclass == C_HALT)        next_state = HALT;
                else if (last_state == T2)   next_state = boundary;
                else                         next_state = T3;
            end
            T3:    next_state = (last_state == T3) ? boundary : T4;
            T4:    next_state = (last_state == T4) ? boundary : T5;
            T5:    next_state = (last_state == T5) ? boundary : T6;
            T6:    next_state = (last_state == T6) ? boundary : T7;
            T7:    next_state = boundary;
            HALT:  next_state = HALT;
            default: next_state = RESET;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        reg_in   = '0;
        reg_out  = '0;
        alu_op   = '0;
        Run      = (state != RESET) && (state != HALT);

        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (iclass)
                    C_ALU, C_IMM: begin
                        reg_out = rb_sel;
                        Yin     = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        reg_out = base_sel;
                        Yin     = 1'b1;
                    end
                    C_MULDIV: begin
                        reg_out = ra_sel;
                        Yin     = 1'b1;
                    end
                    C_NEGNOT: begin
                        reg_out = rb_sel;
                        Zin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (iclass)
                    C_ALU: begin
                        reg_out = rc_sel;
                        Zin     = 1'b1;
                    end
                    C_IMM, C_LD, C_LDI, C_ST: begin
                        Cout = 1'b1;
                        Zin  = 1'b1;
                    end
                    C_MULDIV: begin
                        reg_out = rb_sel;
                        Zin     = 1'b1;
                    end
                    C_NEGNOT: begin
                        Zlowout = 1'b1;
                        reg_in  = ra_sel;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (iclass)
                    C_ALU, C_IMM, C_LDI: begin
                        Zlowout = 1'b1;
                        reg_in  = ra_sel;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (iclass)
                    C_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    C_ST: begin
                        reg_out = ra_sel;
                        MDRin   = 1'b1;
                    end
                    C_MULDIV: begin
                        Zhighout = 1'b1;
                        HIin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (iclass)
                    C_LD: begin
                        MDRout = 1'b1;
                        reg_in = ra_sel;
                    end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (Zin) alu_op = alu_code;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction micro-program reference
// model compared cycle by cycle against the DUT, with directed and random instructions.
module tb_control_sequencer;

    logic        Clock;
    logic        clear_n;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
    logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        Read, Write, Run;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_op;

    typedef struct packed {
        logic pc_out, zh_out, zl_out, mdr_out, hi_out, lo_out, c_out;
        logic pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
        logic rd, wr, run;
        logic [4:0]  alu;
        logic [15:0] rin;
        logic [15:0] rout;
    } ctl_t;

    ctl_t obs;
    ctl_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    control_sequencer dut (
        .Clock(Clock), .clear_n(clear_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Read(Read), .Write(Write),
        .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .Run(Run)
    );

    assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
                  PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
                  Read, Write, Run, alu_op, reg_in, reg_out};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t blank();
        ctl_t c;
        c = '0;
        c.run = 1'b1;
        return c;
    endfunction

    // Reference: the expected strobe sequence of one whole instruction, step by step.
    function automatic void build(input logic [31:0] ir);
        ctl_t s;
        logic [4:0]  op;
        logic [15:0] one, ra, rb, rc, base;
        op   = ir[31:27];
        one  = 16'd1;
        ra   = one << ir[26:23];
        rb   = one << ir[22:19];
        rc   = one << ir[18:15];
        base = (ir[22:19] == 4'd0) ? 16'd0 : rb;
        exp_q.delete();

        s = blank(); s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.pc_in = 1; exp_q.push_back(s);
        s = blank(); s.rd = 1; s.mdr_in = 1; exp_q.push_back(s);
        s = blank(); s.mdr_out = 1; s.ir_in = 1; exp_q.push_back(s);

        if (op >= 5'd3 && op <= 5'd14) begin
            s = blank(); s.rout = rb; s.y_in = 1; exp_q.push_back(s);
            s = blank(); s.z_in = 1;
            if (op <= 5'd11) begin
                s.rout = rc; s.alu = op;
            end else begin
                s.c_out = 1;
                s.alu = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
            end
            exp_q.push_back(s);
            s = blank(); s.zl_out = 1; s.rin = ra; exp_q.push_back(s);
        end else if (op <= 5'd2) begin
            s = blank(); s.rout = base; s.y_in = 1; exp_q.push_back(s);
            s = blank(); s.c_out = 1; s.z_in = 1; s.alu = 5'd3; exp_q.push_back(s);
            if (op == 5'd1) begin
                s = blank(); s.zl_out = 1; s.rin = ra; exp_q.push_back(s);
            end else begin
                s = blank(); s.zl_out = 1; s.mar_in = 1; exp_q.push_back(s);
                if (op == 5'd0) begin
                    s = blank(); s.rd = 1; s.mdr_in = 1; exp_q.push_back(s);
                    s = blank(); s.mdr_out = 1; s.rin = ra; exp_q.push_back(s);
                end else begin
                    s = blank(); s.rout = ra; s.mdr_in = 1; exp_q.push_back(s);
                    s = blank(); s.wr = 1; exp_q.push_back(s);
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            s = blank(); s.rout = ra; s.y_in = 1; exp_q.push_back(s);
            s = blank(); s.rout = rb; s.z_in = 1; s.alu = op; exp_q.push_back(s);
            s = blank(); s.zl_out = 1; s.lo_in = 1; exp_q.push_back(s);
            s = blank(); s.zh_out = 1; s.hi_in = 1; exp_q.push_back(s);
        end else if (op == 5'd17 || op == 5'd18) begin
            s = blank(); s.rout = rb; s.z_in = 1; s.alu = op; exp_q.push_back(s);
            s = blank(); s.zl_out = 1; s.rin = ra; exp_q.push_back(s);
        end
    endfunction

    // Runs one instruction starting in T0. stop_from: -1 never, -2 random, k>=0 high from step k.
    // abort_at >= 0 pulls clear_n low during that step instead of completing.
    task automatic exec(input logic [31:0] ir, input int stop_from, input int abort_at,
                        input string name, output bit halted);
        int n;
        build(ir);
        n = exp_q.size();
        halted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== exp_q[i])
                $display("FAIL %s step %0d: got %h expected %h", name, i, obs, exp_q[i]);
            else
                passes++;
            if (i == 0) IR = ir;
            if (stop_from == -2)      Stop = ($urandom_range(7) == 0);
            else if (stop_from >= 0)  Stop = (i >= stop_from);
            else                      Stop = 1'b0;
            if (i == abort_at) begin
                #2 clear_n = 1'b0;
                #1;
                checks++;
                if (obs !== ctl_t'(0))
                    $display("FAIL %s async_reset: got %h expected %h", name, obs, ctl_t'(0));
                else
                    passes++;
                @(negedge Clock);
                checks++;
                if (obs !== ctl_t'(0))
                    $display("FAIL %s reset_hold: got %h expected %h", name, obs, ctl_t'(0));
                else
                    passes++;
                clear_n = 1'b1;
                Stop = 1'b0;
                return;
            end
        end
        halted = Stop || (ir[31:27] == 5'd27);
    endtask

    task automatic check_halt(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clock);
            Stop = 1'(i & 1);
            checks++;
            if (obs !== ctl_t'(0))
                $display("FAIL %s halt cycle %0d: got %h expected %h", name, i, obs, ctl_t'(0));
            else
                passes++;
        end
    endtask

    // Reset with Stop high as well; reset must still win and leave the DUT heading to T0.
    task automatic apply_reset();
        @(negedge Clock);
        clear_n = 1'b0;
        Stop    = 1'b1;
        @(negedge Clock);
        checks++;
        if (obs !== ctl_t'(0))
            $display("FAIL reset_with_stop: got %h expected %h", obs, ctl_t'(0));
        else
            passes++;
        clear_n = 1'b1;
        Stop    = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        Stop    = 1'b0;
        IR      = '0;
        #3;
        checks++;
        if (obs !== ctl_t'(0))
            $display("FAIL reset_initial: got %h expected %h", obs, ctl_t'(0));
        else
            passes++;
        @(negedge Clock);
        checks++;
        if (obs !== ctl_t'(0))
            $display("FAIL reset_clocked: got %h expected %h", obs, ctl_t'(0));
        else
            passes++;
        clear_n = 1'b1;
    endtask

    task automatic test_directed();
        bit h;
        exec(32'h28918000, -1, -1, "and_r1_r2_r3", h);
        exec(32'h00900005, -1, -1, "ld_r1_5_r2", h);
        exec(32'h79980000, -1, -1, "mul_r3_r3", h);
        exec(32'h10800000, -1, -1, "st_rb0", h);
        exec(32'h0A400007, -1, -1, "ldi", h);
        exec(32'h68918000, -1, -1, "andi", h);
        exec(32'h88900000, -1, -1, "neg", h);
        exec(32'hD0000000, -1, -1, "nop", h);
        exec(32'hF8000000, -1, -1, "undef_as_nop", h);
    endtask

    task automatic test_reset_mid();
        bit h;
        exec(32'h18918000, -1, 4, "add_abort_t4", h);
        exec(32'h18918000, -1, -1, "add_after_abort", h);
    endtask

    task automatic test_stop();
        bit h;
        exec(32'h18918000, 4, -1, "add_stop_t4", h);
        checks++;
        if (h !== 1'b1) $display("FAIL stop_model: got %0d expected 1", h);
        else            passes++;
        check_halt(10, "stop_halt");
        apply_reset();
    endtask

    task automatic test_halt();
        bit h;
        exec(32'hD8000000, -1, -1, "halt_op", h);
        check_halt(10, "halt_op_hold");
        apply_reset();
    endtask

    task automatic test_back_to_back();
        bit h;
        logic [31:0] ir;
        for (int k = 0; k < 60; k++) begin
            ir = $urandom;
            exec(ir, -2, -1, $sformatf("rand%0d_op%0d", k, ir[31:27]), h);
            if (h) begin
                check_halt(2, "rand_halt");
                apply_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_stop();
        test_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
